// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell per clock, LSB first,
// carry held in a flop between bits; subtraction is a + ~b + 1.
module serial_add_sub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-2:0] r_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_sbit;
    logic             w_cmaj;
    logic             w_last;
    logic [WIDTH-1:0] w_rnext;

    assign w_sbit  = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_cmaj  = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);
    assign w_last  = (r_state == S_SHIFT) && (r_cnt == LAST);
    // Only WIDTH-1 earlier sum bits need storage; the final bit goes straight to sum.
    assign w_rnext = {w_sbit, r_sh};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SHIFT;
            S_SHIFT: if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sh    <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= sub ? ~b : b;
                        r_carry <= sub;
                        r_cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_sh    <= w_rnext[WIDTH-1:1];
                    r_carry <= w_cmaj;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        // r_carry here is the carry into the MSB cell
                        r_sum  <= w_rnext;
                        r_cout <= w_cmaj;
                        r_ovf  <= r_carry ^ w_cmaj;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub (WIDTH=8): the driver queues expected results,
// and a negedge monitor pops and compares them whenever done pulses.
module tb_serial_add_sub;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .sub  (sub),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_done = 0;
    int   last_done = -1;
    bit   stream_on = 1'b0;
    exp_t q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Independent reference: plain integer add with signed-overflow rule.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
        logic [W:0]   full;
        logic [W-1:0] bb;
        exp_t         e;
        bb   = ts ? ~tb : tb;
        full = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, ts};
        e.s  = full[W-1:0];
        e.c  = full[W];
        e.o  = (ta[W-1] == bb[W-1]) && (e.s[W-1] != ta[W-1]);
        return e;
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sum", 32'(sum), 32'(e.s));
                check("cout", 32'(cout), 32'(e.c));
                check("ovf", 32'(ovf), 32'(e.o));
            end
            if (stream_on && last_done >= 0) check("done_spacing", 32'(cyc - last_done), 32'd10);
            last_done = stream_on ? cyc : -1;
        end
    end

    task automatic push_exp(input logic [W-1:0] s, input logic c, input logic o);
        exp_t e;
        e.s = s;
        e.c = c;
        e.o = o;
        q.push_back(e);
    endtask

    // Issues one op, waits for it to finish; reports busy cycles and done latency.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                          output int nb, output int dc);
        int acc;
        int g;
        nb = 0;
        dc = -1;
        @(negedge clk);
        a = ta; b = tb; sub = ts; start = 1'b1;
        acc = cyc;
        @(negedge clk);
        start = 1'b0;
        g = 0;
        while (busy && g < 40) begin
            nb++;
            if (done) dc = cyc - acc;
            @(negedge clk);
            g++;
        end
        if (g >= 40) check("op_timeout", 32'(g), 32'd0);
    endtask

    initial begin
        int nb;
        int dc;
        int d0;
        int g;
        int cnt;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout_ovf", 32'({cout, ovf}), 32'd0);

        // 1: basic add, latency and busy length
        push_exp(8'h7F, 1'b0, 1'b0);
        run_op(8'h35, 8'h4A, 1'b0, nb, dc);
        check("t1_done_latency", 32'(dc), 32'd9);
        check("t1_busy_cycles", 32'(nb), 32'(W + 1));

        // 2: carry out and signed overflow on add
        push_exp(8'h00, 1'b1, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, nb, dc);
        push_exp(8'h80, 1'b0, 1'b1);
        run_op(8'h7F, 8'h01, 1'b0, nb, dc);

        // 3: subtraction, borrow and overflow
        push_exp(8'hFE, 1'b0, 1'b0);
        run_op(8'h05, 8'h07, 1'b1, nb, dc);
        push_exp(8'h7F, 1'b1, 1'b1);
        run_op(8'h80, 8'h01, 1'b1, nb, dc);

        // 4: start while busy must be ignored
        d0 = n_done;
        push_exp(8'h55, 1'b0, 1'b0);
        @(negedge clk);
        a = 8'h22; b = 8'h33; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'h11; b = 8'h11; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("t4_done_count", 32'(n_done - d0), 32'd1);
        check("t4_sum_held", 32'(sum), 32'h55);

        // 5: reset mid-shift aborts with no done
        d0 = n_done;
        @(negedge clk);
        a = 8'hAA; b = 8'h0F; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_sum", 32'(sum), 32'd0);
        check("t5_cout_ovf", 32'({cout, ovf}), 32'd0);
        repeat (12) @(negedge clk);
        check("t5_no_done", 32'(n_done - d0), 32'd0);
        push_exp(8'h30, 1'b0, 1'b0);
        run_op(8'h10, 8'h20, 1'b0, nb, dc);

        // 6: start held high, back-to-back random ops
        last_done = -1;
        stream_on = 1'b1;
        @(negedge clk);
        ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
        a = ra; b = rb; sub = rs; start = 1'b1;
        q.push_back(model(ra, rb, rs));
        cnt = 1;
        g = 0;
        while (cnt < 200 && g < 3000) begin
            @(negedge clk);
            g++;
            if (done) begin
                ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
                a = ra; b = rb; sub = rs;
                q.push_back(model(ra, rb, rs));
                cnt++;
            end
        end
        check("t6_ops_issued", 32'(cnt), 32'd200);
        repeat (2) @(negedge clk);
        start = 1'b0;
        g = 0;
        while (q.size() != 0 && g < 40) begin
            @(negedge clk);
            g++;
        end
        check("t6_queue_drained", 32'(q.size()), 32'd0);
        repeat (3) @(negedge clk);
        stream_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
